// File: rtl/data_mem_sized_pkg.sv
// Shared definitions for the sized data memory: access-size codes, FSM states, word width.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package data_mem_sized_pkg;

   localparam int WORD = 64;

   // Access size codes: the access covers 2^size bytes
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/data_mem_sized_lane_align.sv
// Byte-lane work for one memory word: load extract/extend, store merge, alignment check.
// Latency: purely combinational.
// Backpressure: none; it only operates on values the top level presents.
module dmem_lane_align
   import data_mem_sized_pkg::*;
(
   input  logic [1:0]      size,
   input  logic            sign_ext,
   input  logic [2:0]      offset,
   input  logic [WORD-1:0] mem_word,
   input  logic [WORD-1:0] wdata,
   output logic            misaligned,
   output logic [WORD-1:0] load_data,
   output logic [WORD-1:0] store_word
);

   logic [WORD-1:0] rd_shift;
   logic [WORD-1:0] wr_shift;
   logic [7:0]      lane_base;
   logic [7:0]      lane_en;

   // Offset must be a multiple of the access size in bytes
   always_comb begin
      misaligned = 1'b0;
      case (size)
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = offset[0];
         SZ_W:    misaligned = |offset[1:0];
         default: misaligned = |offset;
      endcase
   end

   // Bring the addressed byte to lane 0, then zero- or sign-extend from the top extracted byte
   always_comb begin
      rd_shift  = mem_word >> {offset, 3'b000};
      load_data = rd_shift;
      case (size)
         SZ_B:    load_data = sign_ext ? {{56{rd_shift[7]}},  rd_shift[7:0]}  : {56'd0, rd_shift[7:0]};
         SZ_H:    load_data = sign_ext ? {{48{rd_shift[15]}}, rd_shift[15:0]} : {48'd0, rd_shift[15:0]};
         SZ_W:    load_data = sign_ext ? {{32{rd_shift[31]}}, rd_shift[31:0]} : {32'd0, rd_shift[31:0]};
         default: load_data = rd_shift;
      endcase
   end

   // Move the low store bytes up to the addressed lanes and merge them over the old word
   always_comb begin
      wr_shift = wdata << {offset, 3'b000};
      case (size)
         SZ_B:    lane_base = 8'h01;
         SZ_H:    lane_base = 8'h03;
         SZ_W:    lane_base = 8'h0F;
         default: lane_base = 8'hFF;
      endcase
      lane_en    = lane_base << offset;
      store_word = mem_word;
      for (int k = 0; k < 8; k++) begin
         if (lane_en[k]) begin
            store_word[8*k +: 8] = wr_shift[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/data_mem_sized.sv
// MEM-stage data memory with byte/half/word/dword access, wait states and fault reporting.
// Latency: LATENCY+1 cycles from acceptance to the resp_valid pulse; one access per LATENCY+2 cycles.
// Backpressure: req_ready is high only in IDLE; requests are held off during WAIT and RESP.
module data_mem_sized
   import data_mem_sized_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 32,
   parameter int LATENCY = 0
) (
   input  logic             im_clk,
   input  logic             im_rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_fault
);

   localparam int AW = $clog2(DEPTH);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [1:0]       size_q, size_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             fault_q, fault_d;

   logic [WIDTH-1:0] mem_q [DEPTH];

   // The access is made on the edge entering RESP; with no wait states that is the
   // acceptance edge itself, so the request inputs feed the access directly from IDLE.
   logic             acc_wr;
   logic [1:0]       acc_size;
   logic             acc_sgn;
   logic [WIDTH-1:0] acc_addr;
   logic [WIDTH-1:0] acc_wdata;
   logic [AW-1:0]    acc_idx;
   logic             acc_oor;
   logic             acc_mis;
   logic             acc_fault;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] store_word;
   logic             enter_resp;
   logic             commit;

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_fault = fault_q;

   // Select the access fields: live request from IDLE, latched copy otherwise
   always_comb begin
      acc_wr    = wr_q;
      acc_size  = size_q;
      acc_sgn   = sgn_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state_q == ST_IDLE) begin
         acc_wr    = req_write;
         acc_size  = req_size;
         acc_sgn   = req_signed;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end
   end

   assign acc_idx   = acc_addr[AW+2:3];
   assign acc_oor   = |acc_addr[WIDTH-1:AW+3];
   assign acc_fault = acc_oor | acc_mis;

   dmem_lane_align u_lane_align (
      .size       (acc_size),
      .sign_ext   (acc_sgn),
      .offset     (acc_addr[2:0]),
      .mem_word   (mem_q[acc_idx]),
      .wdata      (acc_wdata),
      .misaligned (acc_mis),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // Next state, wait counter and request capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               size_d  = req_size;
               sgn_d   = req_signed;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (LATENCY > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
   // Reset held low must never let a live request reach the array
   assign commit     = enter_resp && acc_wr && !acc_fault && im_rst_n;

   // Response registers update only on RESP entry and hold otherwise
   always_comb begin
      rdata_d = rdata_q;
      fault_d = fault_q;
      if (enter_resp) begin
         fault_d = acc_fault;
         rdata_d = (acc_fault || acc_wr) ? '0 : load_data;
      end
   end

   // Control and response state with asynchronous reset
   always_ff @(posedge im_clk or negedge im_rst_n) begin
      if (!im_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         size_q  <= SZ_B;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   // Storage array, not reset; written only by a committed store
   always_ff @(posedge im_clk) begin
      if (commit) begin
         mem_q[acc_idx] <= store_word;
      end
   end

endmodule

// File: tb/tb_data_mem_sized.sv
module tb_data_mem_sized;

   localparam int LAT   = 2;
   localparam int DEPTH = 32;
   localparam int NBYTE = 8 * DEPTH;

   logic        im_clk = 1'b0;
   logic        im_rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_fault;

   int checks = 0;
   int failures = 0;

   // Byte-addressed reference memory (little-endian by construction)
   logic [7:0] ref_mem [NBYTE];

   data_mem_sized #(.WIDTH(64), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .im_clk     (im_clk),
      .im_rst_n   (im_rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault)
   );

   always #5 im_clk = ~im_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_fault(input logic [63:0] a, input logic [1:0] sz);
      int n;
      n = 1 << sz;
      return (a >= 64'(NBYTE)) || ((a % 64'(n)) != 0);
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic sg);
      int n;
      logic [63:0] v;
      logic [63:0] b;
      n = 1 << sz;
      v = '0;
      for (int i = 0; i < n; i++) begin
         b = 64'(ref_mem[int'(a) + i]);
         v = v | (b << (8 * i));
      end
      if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
      int n;
      logic [63:0] t;
      n = 1 << sz;
      for (int i = 0; i < n; i++) begin
         t = d >> (8 * i);
         ref_mem[int'(a) + i] = t[7:0];
      end
   endtask

   // One full request/response; checks timing, ready, data and fault against the model
   task automatic access(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] rd, output logic flt);
      logic [63:0] exp_rd;
      bit          exp_flt;
      int          cyc;
      bit          rdy_low;
      exp_flt = ref_fault(a, sz);
      exp_rd  = (exp_flt || wr) ? 64'd0 : ref_load(a, sz, sg);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      @(posedge im_clk); #1;
      req_valid = 1'b0;
      cyc = 0;
      rdy_low = 1'b1;
      while (!resp_valid && cyc < 20) begin
         if (req_ready !== 1'b0) rdy_low = 1'b0;
         @(posedge im_clk); #1;
         cyc++;
      end
      if (req_ready !== 1'b0) rdy_low = 1'b0;
      chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
      chk({tag, "_rdylow"}, 64'(rdy_low), 64'd1);
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_fault"}, 64'(resp_fault), 64'(exp_flt));
      rd  = resp_rdata;
      flt = resp_fault;
      if (wr && !exp_flt) ref_store(a, sz, d);
      @(posedge im_clk); #1;
      chk({tag, "_pulse"}, {62'd0, resp_valid, req_ready}, 64'b01);
   endtask

   initial begin
      logic [63:0] rd;
      logic        flt;
      logic [63:0] a;
      logic [63:0] d;
      logic [1:0]  sz;
      logic        wr;
      logic        sg;
      bit          saw;

      // Reset held for 3 cycles
      repeat (3) @(posedge im_clk);
      #1;
      chk("rst_outs", {61'd0, resp_valid, resp_fault, req_ready}, 64'b001);
      chk("rst_rdata", resp_rdata, 64'd0);
      im_rst_n = 1'b1;

      // Fill every word with known random data
      for (int w = 0; w < DEPTH; w++) begin
         access("init", 1'b1, 2'b11, 1'b0, 64'(8 * w), {$urandom, $urandom}, rd, flt);
      end

      // Dword store then load
      access("st_d", 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, rd, flt);
      access("ld_d", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, rd, flt);
      chk("ld_d_const", rd, 64'h1122334455667788);

      // Byte store and reads back
      access("st_b", 1'b1, 2'b00, 1'b0, 64'h13, 64'hAB, rd, flt);
      access("ld_d2", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, rd, flt);
      chk("ld_d2_const", rd, 64'h11223344AB667788);
      access("ld_sb", 1'b0, 2'b00, 1'b1, 64'h13, 64'h0, rd, flt);
      chk("ld_sb_const", rd, 64'hFFFFFFFFFFFFFFAB);
      access("ld_ub", 1'b0, 2'b00, 1'b0, 64'h13, 64'h0, rd, flt);
      chk("ld_ub_const", rd, 64'h00000000000000AB);
      // Response registers hold after the pulse
      repeat (2) @(posedge im_clk);
      #1;
      chk("hold_rdata", resp_rdata, 64'h00000000000000AB);

      // Misaligned accesses
      access("mis_h", 1'b0, 2'b01, 1'b0, 64'h11, 64'h0, rd, flt);
      chk("mis_h_const", {63'd0, flt}, 64'd1);
      access("mis_w", 1'b1, 2'b10, 1'b0, 64'h16, 64'hDEADBEEF, rd, flt);
      chk("mis_w_const", {63'd0, flt}, 64'd1);
      access("mis_chk", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, rd, flt);
      chk("mis_chk_const", rd, 64'h11223344AB667788);

      // Range boundary
      access("oor", 1'b0, 2'b11, 1'b0, 64'h100, 64'h0, rd, flt);
      chk("oor_const", {63'd0, flt}, 64'd1);
      access("inr", 1'b0, 2'b11, 1'b0, 64'hF8, 64'h0, rd, flt);
      chk("inr_const", {63'd0, flt}, 64'd0);
      access("oor_hi", 1'b1, 2'b11, 1'b0, 64'h0000_0100_0000_0010, 64'h5A5A, rd, flt);
      access("oor_hi_chk", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, rd, flt);

      // Reset pulse while a store is waiting
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_signed = 1'b0;
      req_addr = 64'h10; req_wdata = 64'hFFFFFFFFFFFFFFFF;
      @(posedge im_clk); #1;
      req_valid = 1'b0;
      im_rst_n = 1'b0;
      #2;
      chk("midrst_outs", {61'd0, resp_valid, resp_fault, req_ready}, 64'b001);
      im_rst_n = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < LAT + 3; i++) begin
         @(posedge im_clk); #1;
         if (resp_valid !== 1'b0) saw = 1'b1;
      end
      chk("midrst_noresp", 64'(saw), 64'd0);
      access("midrst_ld", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, rd, flt);
      chk("midrst_ld_const", rd, 64'h11223344AB667788);

      // Randomized mix against the reference model
      for (int i = 0; i < 150; i++) begin
         a  = 64'($urandom_range(0, NBYTE + 15));
         if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(9, 63));
         sz = 2'($urandom_range(0, 3));
         wr = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         d  = {$urandom, $urandom};
         access("rnd", wr, sz, sg, a, d, rd, flt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
